// File: rtl/capture_drain_sched.sv
// Round-robin drain of four per-channel byte FIFOs into framed UDP packets (header + payload + gap).
// Optional build macro SCHED_CHKSUM_EN appends an XOR checksum byte after each payload.
module capture_drain_sched #(
    parameter int unsigned PKT_BYTES  = 1024,
    parameter int unsigned IFG_CYCLES = 16,
    parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        arm,
    input  logic        full_any,
    input  logic [3:0]  empty,
    input  logic [31:0] fifo_dout,
    output logic [3:0]  rd_en,
    output logic [1:0]  ch_sel,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_busy,
    output logic [15:0] seq,
    output logic        done,
    output logic        active
);

    typedef enum logic [2:0] {
        IDLE, ARMED, SELECT, WAIT_TX, HDR, PAYLOAD, CHK, GAP
    } state_t;

    localparam logic [15:0]    PKT_MAX  = 16'(PKT_BYTES);
    localparam int unsigned    GW       = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
    localparam logic [GW-1:0]  GAP_LAST = GW'(IFG_CYCLES - 1);
`ifdef SCHED_CHKSUM_EN
    localparam state_t         END_ST   = CHK;
`else
    localparam state_t         END_ST   = GAP;
`endif

    state_t        state_q, state_d;
    logic [1:0]    ch_q, ch_d;
    logic [1:0]    last_q, last_d;
    logic [1:0]    hdr_cnt_q, hdr_cnt_d;
    logic [15:0]   seq_q, seq_d;
    logic [15:0]   rd_cnt_q, rd_cnt_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    logic [7:0]    chk_q, chk_d;
    logic          done_q, done_d;
    logic          active_q, active_d;

    logic          rr_found;
    logic [1:0]    rr_ch;
    logic [1:0]    cand;
    logic          rd_ok;
    logic [7:0]    pay_byte;

    assign pay_byte = fifo_dout[{ch_q, 3'b000} +: 8];
    assign rd_ok    = (rd_cnt_q < PKT_MAX) && !empty[ch_q];

    // Search order starts at the channel after the last one served.
    always_comb begin
        rr_found = 1'b0;
        rr_ch    = last_q;
        cand     = '0;
        for (int unsigned k = 1; k <= 4; k++) begin
            cand = last_q + 2'(k);
            if (!rr_found && !empty[cand]) begin
                rr_found = 1'b1;
                rr_ch    = cand;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            ch_q      <= '0;
            last_q    <= 2'd3;
            hdr_cnt_q <= '0;
            seq_q     <= '0;
            rd_cnt_q  <= '0;
            gap_cnt_q <= '0;
            chk_q     <= '0;
            done_q    <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            last_q    <= last_d;
            hdr_cnt_q <= hdr_cnt_d;
            seq_q     <= seq_d;
            rd_cnt_q  <= rd_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            chk_q     <= chk_d;
            done_q    <= done_d;
            active_q  <= active_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        last_d    = last_q;
        hdr_cnt_d = hdr_cnt_q;
        seq_d     = seq_q;
        rd_cnt_d  = rd_cnt_q;
        gap_cnt_d = gap_cnt_q;
        chk_d     = chk_q;
        done_d    = 1'b0;
        active_d  = active_q;
        case (state_q)
            IDLE: begin
                if (arm) begin
                    state_d  = ARMED;
                    active_d = 1'b1;
                end
            end
            ARMED: begin
                if (full_any) state_d = SELECT;
            end
            SELECT: begin
                if (rr_found) begin
                    ch_d    = rr_ch;
                    last_d  = rr_ch;
                    state_d = WAIT_TX;
                end else begin
                    done_d   = 1'b1;
                    active_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            WAIT_TX: begin
                if (!tx_busy) begin
                    state_d   = HDR;
                    hdr_cnt_d = '0;
                end
            end
            HDR: begin
                hdr_cnt_d = hdr_cnt_q + 2'd1;
                if (hdr_cnt_q == 2'd0) begin
                    seq_d    = seq_q + 16'd1;
                    rd_cnt_d = '0;
                    chk_d    = '0;
                end
                if (hdr_cnt_q == 2'd3) begin
                    gap_cnt_d = '0;
                    if (rd_ok) begin
                        rd_cnt_d = rd_cnt_q + 16'd1;
                        state_d  = PAYLOAD;
                    end else begin
                        state_d = END_ST;
                    end
                end
            end
            PAYLOAD: begin
                chk_d = chk_q ^ pay_byte;
                if (rd_ok) begin
                    rd_cnt_d = rd_cnt_q + 16'd1;
                end else begin
                    gap_cnt_d = '0;
                    state_d   = END_ST;
                end
            end
            CHK: begin
                gap_cnt_d = '0;
                state_d   = GAP;
            end
            GAP: begin
                // The next channel is chosen on the last gap cycle so the idle run is exactly IFG_CYCLES.
                if (gap_cnt_q == GAP_LAST) begin
                    if (rr_found) begin
                        ch_d      = rr_ch;
                        last_d    = rr_ch;
                        hdr_cnt_d = '0;
                        state_d   = tx_busy ? WAIT_TX : HDR;
                    end else begin
                        done_d   = 1'b1;
                        active_d = 1'b0;
                        state_d  = IDLE;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + GW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rd_en    = '0;
        tx_valid = 1'b0;
        tx_data  = '0;
        case (state_q)
            HDR: begin
                tx_valid = 1'b1;
                case (hdr_cnt_q)
                    2'd0:    tx_data = SYNC_BYTE;
                    2'd1:    tx_data = {6'b0, ch_q};
                    2'd2:    tx_data = seq_q[15:8];
                    default: tx_data = seq_q[7:0];
                endcase
                if (hdr_cnt_q == 2'd3 && rd_ok) rd_en[ch_q] = 1'b1;
            end
            PAYLOAD: begin
                tx_valid = 1'b1;
                tx_data  = pay_byte;
                if (rd_ok) rd_en[ch_q] = 1'b1;
            end
            CHK: begin
                tx_valid = 1'b1;
                tx_data  = chk_q;
            end
            default: ;
        endcase
    end

    assign ch_sel = ch_q;
    assign seq    = seq_q;
    assign done   = done_q;
    assign active = active_q;

endmodule

// File: tb/tb_capture_drain_sched.sv
// Self-checking bench for capture_drain_sched: FIFO model, stream monitor and packet-level reference model.
module tb_capture_drain_sched;
    localparam int PKT = 1024;
    localparam int IFG = 16;
`ifdef SCHED_CHKSUM_EN
    localparam int CHK_EN = 1;
`else
    localparam int CHK_EN = 0;
`endif

    logic        clk = 1'b0, rst = 1'b1, arm = 1'b0, full_any = 1'b0, tx_busy = 1'b0;
    logic [3:0]  empty_r = 4'hF;
    logic [7:0]  dout_b [4] = '{default: 8'h00};
    logic [31:0] fifo_dout;
    logic [3:0]  rd_en;
    logic [1:0]  ch_sel;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic [15:0] seq;
    logic        done, active;

    int total = 0, bad = 0, viol = 0, cyc = 0, scen = 0;
    logic [7:0] fq  [4][$];
    logic [7:0] src [4][$];

    logic [7:0] cap_bytes[$];
    int cap_start[$], cap_len[$], cap_gap[$], cap_ch[$], cap_scen[$], cap_cyc[$];
    int in_pkt = 0, cur_len = 0, cur_ch = 0, last_vcyc = -1000, chsel_bad = 0, done_cnt = 0;

    assign fifo_dout = {dout_b[3], dout_b[2], dout_b[1], dout_b[0]};

    always #4 clk = ~clk;

    capture_drain_sched #(
        .PKT_BYTES (PKT),
        .IFG_CYCLES(IFG),
        .SYNC_BYTE (8'hA5)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .arm      (arm),
        .full_any (full_any),
        .empty    (empty_r),
        .fifo_dout(fifo_dout),
        .rd_en    (rd_en),
        .ch_sel   (ch_sel),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_busy  (tx_busy),
        .seq      (seq),
        .done     (done),
        .active   (active)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Byte FIFOs with registered output: data valid the cycle after rd_en.
    always @(posedge clk) begin
        if ($countones(rd_en) > 1) viol++;
        for (int i = 0; i < 4; i++) begin
            if (rd_en[i] === 1'b1) begin
                if (fq[i].size() == 0) viol++;
                else dout_b[i] <= fq[i].pop_front();
            end
            empty_r[i] <= (fq[i].size() == 0);
        end
    end

    always @(negedge clk) begin
        if (tx_valid === 1'b1) begin
            if (in_pkt == 0) begin
                in_pkt = 1;
                cur_len = 0;
                cur_ch = int'(ch_sel);
                cap_start.push_back(cap_bytes.size());
                cap_gap.push_back(cyc - last_vcyc - 1);
                cap_ch.push_back(int'(ch_sel));
                cap_scen.push_back(scen);
                cap_cyc.push_back(cyc);
            end
            cap_bytes.push_back(tx_data);
            cur_len++;
            if (int'(ch_sel) != cur_ch) chsel_bad++;
            last_vcyc = cyc;
        end else if (in_pkt != 0) begin
            in_pkt = 0;
            cap_len.push_back(cur_len);
        end
        if (done === 1'b1) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; arm = 1'b0; full_any = 1'b0; tx_busy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            fq[i].delete();
            src[i].delete();
        end
        tick(2);
        rst = 1'b0;
        tick(1);
        scen++;
    endtask

    task automatic load(input int ch, input int n, input int pattern);
        logic [7:0] b;
        for (int j = 0; j < n; j++) begin
            b = (pattern != 0) ? 8'(j) : 8'($urandom_range(0, 255));
            fq[ch].push_back(b);
            src[ch].push_back(b);
        end
    endtask

    // Reference: walk channels round-robin, carve each into PKT-sized packets.
    task automatic verify(input string nm);
        logic [7:0] eb[$];
        int elen[$], ech[$], idx[$];
        int m_last, m_seq, c, n, np, eoff, cs, mm, lim;
        logic [7:0] x;
        m_last = 3; m_seq = 0;
        for (int guard = 0; guard < 1000; guard++) begin
            c = -1;
            for (int k = 1; k <= 4; k++)
                if (c < 0 && src[(m_last + k) % 4].size() > 0) c = (m_last + k) % 4;
            if (c < 0) break;
            n = (src[c].size() < PKT) ? src[c].size() : PKT;
            m_seq = (m_seq + 1) % 65536;
            eb.push_back(8'hA5); eb.push_back(8'(c));
            eb.push_back(8'(m_seq >> 8)); eb.push_back(8'(m_seq));
            x = 8'h00;
            for (int j = 0; j < n; j++) begin
                x = x ^ src[c][0];
                eb.push_back(src[c].pop_front());
            end
            if (CHK_EN != 0) eb.push_back(x);
            elen.push_back(4 + n + CHK_EN);
            ech.push_back(c);
            m_last = c;
        end
        for (int i = 0; i < cap_scen.size(); i++)
            if (cap_scen[i] == scen && i < cap_len.size()) idx.push_back(i);
        chk({nm, " npkts"}, idx.size(), elen.size());
        chk({nm, " seq"}, 32'(seq), 32'(m_seq));
        np = (idx.size() < elen.size()) ? idx.size() : elen.size();
        eoff = 0;
        for (int i = 0; i < np; i++) begin
            chk({nm, " len"}, cap_len[idx[i]], elen[i]);
            chk({nm, " ch_sel"}, cap_ch[idx[i]], ech[i]);
            if (i > 0) chk({nm, " gap"}, cap_gap[idx[i]], IFG);
            cs = cap_start[idx[i]];
            lim = (cap_len[idx[i]] < elen[i]) ? cap_len[idx[i]] : elen[i];
            mm = -1;
            for (int j = 0; j < lim; j++)
                if (mm < 0 && cap_bytes[cs + j] !== eb[eoff + j]) mm = j;
            chk({nm, " bytes mismatch_at"}, mm, -1);
            eoff += elen[i];
        end
    endtask

    task automatic run(input string nm, input int busy_cycles, output int fall);
        int d0;
        d0 = done_cnt;
        arm = 1'b1;
        tick(1);
        arm = 1'b0;
        chk({nm, " active after arm"}, active, 1);
        tick(1);
        full_any = 1'b1;
        tx_busy = (busy_cycles > 0);
        tick(1);
        full_any = 1'b0;
        if (busy_cycles > 0) tick(busy_cycles);
        tx_busy = 1'b0;
        fall = cyc;
        for (int t = 0; t < 20000 && done_cnt == d0; t++) tick(1);
        chk({nm, " done seen"}, (done_cnt > d0), 1);
        tick(3);
        chk({nm, " done pulses"}, done_cnt - d0, 1);
        chk({nm, " active after done"}, active, 0);
        verify(nm);
    endtask

    initial begin
        int fall, first;
        do_reset();
        chk("rst rd_en", rd_en, 0);
        chk("rst ch_sel", ch_sel, 0);
        chk("rst tx_valid", tx_valid, 0);
        chk("rst tx_data", tx_data, 0);
        chk("rst seq", seq, 0);
        chk("rst done", done, 0);
        chk("rst active", active, 0);

        run("all_empty", 0, fall);

        do_reset();
        load(0, 2048, 1);
        run("ch0_2048", 0, fall);

        do_reset();
        for (int c = 0; c < 4; c++) load(c, 10, 0);
        run("four_ch_10", 0, fall);

        do_reset();
        load(2, 20, 0);
        load(3, 3, 0);
        run("busy50", 50, fall);
        first = -1;
        for (int i = 0; i < cap_scen.size(); i++)
            if (first < 0 && cap_scen[i] == scen) first = i;
        chk("busy50 first hdr cycle", (first >= 0) ? cap_cyc[first] : -1, fall + 1);

        do_reset();
        load(1, 1500, 0);
        arm = 1'b1; tick(1); arm = 1'b0; tick(1);
        full_any = 1'b1; tick(1); full_any = 1'b0;
        for (int t = 0; t < 3000 && !(in_pkt != 0 && cur_len >= 304); t++) tick(1);
        chk("midrst reached byte 300", (in_pkt != 0 && cur_len >= 304), 1);
        rst = 1'b1;
        #1;
        chk("midrst rd_en", rd_en, 0);
        chk("midrst ch_sel", ch_sel, 0);
        chk("midrst tx_valid", tx_valid, 0);
        chk("midrst tx_data", tx_data, 0);
        chk("midrst seq", seq, 0);
        chk("midrst active", active, 0);
        do_reset();
        load(0, 5, 0);
        run("rearm", 0, fall);

        do_reset();
        fq[0].push_back(8'h01); fq[0].push_back(8'h02); fq[0].push_back(8'h04);
        src[0].push_back(8'h01); src[0].push_back(8'h02); src[0].push_back(8'h04);
        run("chksum", 0, fall);
        first = cap_len.size() - 1;
        chk("chksum run length", cap_len[first], (CHK_EN != 0) ? 8 : 7);
        if (CHK_EN != 0) chk("chksum trailer", cap_bytes[cap_start[first] + 7], 8'h07);

        do_reset();
        load(0, 1024, 0); load(1, 1025, 0); load(2, 1, 0);
        run("boundary", 0, fall);

        for (int it = 0; it < 3; it++) begin
            do_reset();
            for (int c = 0; c < 4; c++) load(c, $urandom_range(0, 1300), 0);
            run($sformatf("rand%0d", it), 0, fall);
        end

        chk("fifo read violations", viol, 0);
        chk("ch_sel stable in packet", chsel_bad, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/capture_drain_sched.md
Name: capture_drain_sched

Overview:
- Sequences the drain of the four per-channel byte FIFOs (the 16-to-8 width converters after the ADC CDCs) into the UDP transmit stream.
- Replaces the simple read controller in the 125 MHz domain.
- Arms on a capture, waits for any FIFO to fill, then visits channels round-robin and emits framed packets (header + payload) with a mandatory inter-packet gap.
- Drives the byte mux select and the UDP valid/data.

Parameters:
PKT_BYTES, 1024, max payload bytes per packet (2..65535)
IFG_CYCLES, 16, idle cycles between packets (>=1)
SYNC_BYTE, 8'hA5, first header byte

Ports:
clk  in  1  125 MHz clock
rst  in  1  asynchronous reset, active-high
arm  in  1  single-cycle start pulse (aligned & debounced button)
full_any  in  1  OR of the four FIFO full flags
empty  in  4  per-channel FIFO empty, bit i = channel i
fifo_dout  in  32  channel i byte on bits [8i+7:8i]; valid cycle after rd_en
rd_en  out  4  per-channel FIFO read enable, at most one bit set
ch_sel  out  2  channel currently owning the stream
tx_valid  out  1  UDP byte valid; contiguous for a whole packet
tx_data  out  8  UDP byte
tx_busy  in  1  UDP engine busy; new packet may not start while high
seq  out  16  sequence number of the last packet started
done  out  1  single-cycle pulse when all FIFOs have been drained
active  out  1  high from arm accepted until done

Behaviour:
- Reset values: rd_en=0, ch_sel=0, tx_valid=0, tx_data=0, seq=0, done=0, active=0, state=IDLE. Reset mid-packet truncates the packet immediately; no trailing bytes.
- IDLE: arm -> ARMED, active=1. arm ignored in every other state.
- ARMED: full_any -> SELECT.
- SELECT: round-robin search starts at the channel after the last one served (ch 0 after reset), skipping channels with empty=1.
  - Found -> ch_sel latched, WAIT_TX.
  - All four empty -> done pulse, active=0, IDLE.
- WAIT_TX: stay while tx_busy=1, else HDR.
- HDR: 4 consecutive tx_valid cycles: SYNC_BYTE, {6'b0,ch_sel}, seq_next[15:8], seq_next[7:0].
  - seq increments (16-bit, wraps 0xFFFF->0x0000) at the first header byte.
  - rd_en[ch_sel] asserts on the 4th header cycle, so the first payload byte follows with no bubble.
- PAYLOAD: tx_data = fifo_dout byte of ch_sel, registered one cycle after rd_en. rd_en stays high while byte count < PKT_BYTES and empty[ch_sel]=0.
  - Packet ends after PKT_BYTES payload bytes, or early when empty[ch_sel]=1 at a read decision (the payload then has fewer bytes).
  - Never read an empty FIFO.
  - tx_valid stays continuously high from the first header byte to the last payload byte.
- GAP: tx_valid=0 for exactly IFG_CYCLES, then SELECT.
- Payload latency: 1 cycle from rd_en to tx_valid/tx_data.
- ch_sel is stable from SELECT exit until GAP exit.
- full_any asserting during drain is ignored.

Optional Feature:
- Macro SCHED_CHKSUM_EN defined: one extra byte is appended after the last payload byte, still inside the contiguous tx_valid run. The byte is the XOR of all payload bytes of that packet (0x00 for an empty payload).
- Undefined: no trailer; the packet ends on the last payload byte.

Test Plan:
- Reset, then arm with all FIFOs empty and full_any pulsed -> no tx_valid, done pulses once, active 1->0.
- Ch0 holds 2048 bytes 0x00..0xFF repeating, others empty, PKT_BYTES=1024 -> two packets:
  - Header A5 00 00 01, then 1024 bytes.
  - Header A5 00 00 02, then 1024 bytes.
  - Exactly 16 idle cycles between the packets, then done.
- All four channels hold 10 bytes -> packets in channel order 0,1,2,3, each with a 10-byte payload, seq 1..4, ch_sel matching header byte 2.
- tx_busy held high for 50 cycles after ARMED->SELECT -> first header byte appears 1 cycle after tx_busy falls. A fifo_dout byte read one cycle after rd_en appears unchanged on tx_data.
- rst asserted at payload byte 300 -> all outputs at reset values in the same cycle. Re-arm yields seq=1 with header A5 00 00 01.
- With SCHED_CHKSUM_EN and payload 01 02 04 -> trailer byte 0x07; total tx_valid run = 4+3+1 = 8 cycles.
